// File: rtl/ysyx_040750_ex_pkg.sv
// Shared types and default parameters for the execute-stage controller.
package ysyx_040750_ex_pkg;

  localparam int unsigned XLEN_DEF       = 64;
  localparam int unsigned MC_TIMEOUT_DEF = 80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ysyx_040750_ex_ctrl_if.sv
// Handshake bundle between ID/EX, the shared ALU, EX/MEM and the EX controller.
// YSYX_040750_EX_PERF_EN adds the two performance counter outputs.
interface ysyx_040750_ex_ctrl_if
  import ysyx_040750_ex_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            I_in_valid;
  logic            I_multicycle;
  logic            O_in_ready;
  logic            I_flush;
  logic            O_alu_multicycle;
  logic            O_alu_ack;
  logic [XLEN-1:0] I_alu_result;
  logic            I_alu_result_valid;
  logic            O_out_valid;
  logic            I_out_ready;
  logic [XLEN-1:0] O_out_result;
  logic            O_busy;
  logic            O_timeout_err;
`ifdef YSYX_040750_EX_PERF_EN
  logic [63:0]     O_perf_mc_cycles;
  logic [63:0]     O_perf_bp_cycles;
`endif

  // Controller side
  modport master (
    input  I_in_valid, I_multicycle, I_flush, I_alu_result, I_alu_result_valid, I_out_ready,
`ifdef YSYX_040750_EX_PERF_EN
    output O_perf_mc_cycles, O_perf_bp_cycles,
`endif
    output O_in_ready, O_alu_multicycle, O_alu_ack, O_out_valid, O_out_result, O_busy,
           O_timeout_err
  );

  // Pipeline/ALU side
  modport slave (
    output I_in_valid, I_multicycle, I_flush, I_alu_result, I_alu_result_valid, I_out_ready,
`ifdef YSYX_040750_EX_PERF_EN
    input  O_perf_mc_cycles, O_perf_bp_cycles,
`endif
    input  O_in_ready, O_alu_multicycle, O_alu_ack, O_out_valid, O_out_result, O_busy,
           O_timeout_err
  );

endinterface

// File: rtl/ysyx_040750_ex_outbuf.sv
// One-entry valid/ready result slot; capture and drain in the same cycle keeps it full.
module ysyx_040750_ex_outbuf
  import ysyx_040750_ex_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic [XLEN-1:0] data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            slot_free_c
);

  assign slot_free_c = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_result <= data;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_040750_ex_ctrl.sv
// Execute-stage controller: sequences the shared ALU, buffers one result, aborts on flush/timeout.
// Optional build macro YSYX_040750_EX_PERF_EN adds saturating BUSY / back-pressure cycle counters.
module ysyx_040750_ex_ctrl
  import ysyx_040750_ex_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEF
) (
  input logic                  I_sys_clk,
  input logic                  I_rst,
  ysyx_040750_ex_ctrl_if.master ex
);

  localparam int unsigned CNT_W = $clog2(MC_TIMEOUT + 1);

  ex_state_e  state;
  logic [CNT_W-1:0] cnt;
  logic       alu_mc_q;
  logic       busy_q;
  logic       timeout_q;

  logic       slot_free_c;
  logic       capture;
  logic       in_ready_c;
  logic       ack_c;
  logic       to_busy;
  logic       to_abort;
  logic       timeout_hit;

  // Per-cycle decode of consume/capture/abort from the current state and inputs
  always_comb begin
    capture     = 1'b0;
    in_ready_c  = 1'b0;
    ack_c       = 1'b0;
    to_busy     = 1'b0;
    to_abort    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ex.I_in_valid && !ex.I_flush) begin
          if (ex.I_multicycle) begin
            to_busy = 1'b1;
          end else begin
            in_ready_c = slot_free_c;
            capture    = slot_free_c;
          end
        end
      end
      ST_BUSY: begin
        if (ex.I_flush) begin
          to_abort = 1'b1;
        end else if (ex.I_alu_result_valid && slot_free_c) begin
          capture    = 1'b1;
          in_ready_c = 1'b1;
          ack_c      = 1'b1;
        end else if (cnt == CNT_W'(MC_TIMEOUT - 1)) begin
          to_abort    = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      ST_ABORT: ack_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_mc_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (to_busy) begin
            state    <= ST_BUSY;
            cnt      <= '0;
            alu_mc_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (capture) begin
            state    <= ST_IDLE;
            alu_mc_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (to_abort) begin
            state    <= ST_ABORT;
            alu_mc_q <= 1'b0;
            if (timeout_hit) timeout_q <= 1'b1;
          end
        end
        ST_ABORT: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          alu_mc_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  ysyx_040750_ex_outbuf #(.XLEN(XLEN)) u_outbuf (
    .clk         (I_sys_clk),
    .rst         (I_rst),
    .capture     (capture),
    .data        (ex.I_alu_result),
    .out_ready   (ex.I_out_ready),
    .out_valid   (ex.O_out_valid),
    .out_result  (ex.O_out_result),
    .slot_free_c (slot_free_c)
  );

  assign ex.O_in_ready       = in_ready_c;
  assign ex.O_alu_ack        = ack_c;
  assign ex.O_alu_multicycle = alu_mc_q;
  assign ex.O_busy           = busy_q;
  assign ex.O_timeout_err    = timeout_q;

`ifdef YSYX_040750_EX_PERF_EN
  logic [63:0] perf_mc_q;
  logic [63:0] perf_bp_q;

  // Saturating counters: cycles spent in BUSY, cycles the full slot is stalled
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      perf_mc_q <= '0;
      perf_bp_q <= '0;
    end else begin
      if (state == ST_BUSY && perf_mc_q != '1) perf_mc_q <= perf_mc_q + 64'd1;
      if (ex.O_out_valid && !ex.I_out_ready && perf_bp_q != '1) perf_bp_q <= perf_bp_q + 64'd1;
    end
  end

  assign ex.O_perf_mc_cycles = perf_mc_q;
  assign ex.O_perf_bp_cycles = perf_bp_q;
`endif

endmodule

// File: tb/tb_ysyx_040750_ex_ctrl.sv
// Self-checking bench for ysyx_040750_ex_ctrl: directed scenarios plus a randomized slot scoreboard.
module tb_ysyx_040750_ex_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ysyx_040750_ex_ctrl_if #(.XLEN(64)) ex ();

  ysyx_040750_ex_ctrl #(.XLEN(64), .MC_TIMEOUT(80)) dut (
    .I_sys_clk (clk),
    .I_rst     (rst),
    .ex        (ex)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    ex.I_in_valid         = 1'b0;
    ex.I_multicycle       = 1'b0;
    ex.I_flush            = 1'b0;
    ex.I_alu_result       = '0;
    ex.I_alu_result_valid = 1'b0;
    ex.I_out_ready        = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({ex.O_out_valid, ex.O_busy, ex.O_alu_multicycle, ex.O_timeout_err, ex.O_in_ready, ex.O_alu_ack} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 000000", {ex.O_out_valid, ex.O_busy, ex.O_alu_multicycle, ex.O_timeout_err, ex.O_in_ready, ex.O_alu_ack});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d [4];
    ex.I_out_ready  = 1'b1;
    ex.I_multicycle = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i] = rnd64();
      ex.I_in_valid   = 1'b1;
      ex.I_alu_result = d[i];
      #1;
      n_cmp++;
      if (ex.O_in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, ex.O_in_ready);
      end
      step();
      n_cmp++;
      if (ex.O_out_valid !== 1'b1 || ex.O_out_result !== d[i]) begin
        n_err++;
        $display("FAIL b2b_result[%0d]: got v=%b %h want v=1 %h", i, ex.O_out_valid, ex.O_out_result, d[i]);
      end
    end
    ex.I_in_valid = 1'b0;
    step();
    n_cmp++;
    if (ex.O_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got %b want 0", ex.O_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] nxt;
    nxt = rnd64();
    ex.I_out_ready  = 1'b0;
    ex.I_in_valid   = 1'b1;
    ex.I_multicycle = 1'b0;
    ex.I_alu_result = 64'h1234;
    #1;
    n_cmp++;
    if (ex.O_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first_ready: got %b want 1", ex.O_in_ready);
    end
    step();
    ex.I_alu_result = nxt;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ex.O_in_ready !== 1'b0 || ex.O_out_valid !== 1'b1 || ex.O_out_result !== 64'h1234) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b %h want rdy=0 v=1 1234", i, ex.O_in_ready, ex.O_out_valid, ex.O_out_result);
      end
      step();
    end
    ex.I_out_ready = 1'b1;
    #1;
    n_cmp++;
    if (ex.O_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b want 1", ex.O_in_ready);
    end
    step();
    ex.I_in_valid = 1'b0;
    n_cmp++;
    if (ex.O_out_valid !== 1'b1 || ex.O_out_result !== nxt) begin
      n_err++;
      $display("FAIL bp_next_result: got v=%b %h want v=1 %h", ex.O_out_valid, ex.O_out_result, nxt);
    end
    step();
  endtask

  task automatic test_multicycle_done();
    logic [63:0] r;
    r = rnd64();
    ex.I_out_ready  = 1'b1;
    ex.I_in_valid   = 1'b1;
    ex.I_multicycle = 1'b1;
    #1;
    n_cmp++;
    if (ex.O_in_ready !== 1'b0 || ex.O_alu_multicycle !== 1'b0) begin
      n_err++;
      $display("FAIL mc_present: got rdy=%b mc=%b want 0 0", ex.O_in_ready, ex.O_alu_multicycle);
    end
    step();
    for (int k = 1; k <= 32; k++) begin
      n_cmp++;
      if ({ex.O_alu_multicycle, ex.O_busy, ex.O_in_ready, ex.O_alu_ack} !== 4'b1100) begin
        n_err++;
        $display("FAIL mc_busy[%0d]: got %b want 1100", k, {ex.O_alu_multicycle, ex.O_busy, ex.O_in_ready, ex.O_alu_ack});
      end
      step();
    end
    ex.I_alu_result_valid = 1'b1;
    ex.I_alu_result       = r;
    #1;
    n_cmp++;
    if ({ex.O_in_ready, ex.O_alu_ack} !== 2'b11) begin
      n_err++;
      $display("FAIL mc_done_pulse: got %b want 11", {ex.O_in_ready, ex.O_alu_ack});
    end
    step();
    ex.I_alu_result_valid = 1'b0;
    ex.I_in_valid         = 1'b0;
    ex.I_multicycle       = 1'b0;
    n_cmp++;
    if (ex.O_out_valid !== 1'b1 || ex.O_out_result !== r || ex.O_busy !== 1'b0 || ex.O_alu_multicycle !== 1'b0) begin
      n_err++;
      $display("FAIL mc_result: got v=%b %h busy=%b mc=%b want v=1 %h busy=0 mc=0", ex.O_out_valid, ex.O_out_result, ex.O_busy, ex.O_alu_multicycle, r);
    end
    step();
  endtask

  task automatic test_flush_vs_valid();
    ex.I_out_ready  = 1'b1;
    ex.I_in_valid   = 1'b1;
    ex.I_multicycle = 1'b1;
    step();
    for (int k = 0; k < int'($urandom_range(2, 6)); k++) step();
    ex.I_flush            = 1'b1;
    ex.I_alu_result_valid = 1'b1;
    ex.I_alu_result       = rnd64();
    #1;
    n_cmp++;
    if (ex.O_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_consume: got %b want 0", ex.O_in_ready);
    end
    step();
    ex.I_flush            = 1'b0;
    ex.I_alu_result_valid = 1'b0;
    ex.I_in_valid         = 1'b0;
    ex.I_multicycle       = 1'b0;
    #1;
    n_cmp++;
    if ({ex.O_busy, ex.O_alu_multicycle, ex.O_alu_ack, ex.O_in_ready, ex.O_out_valid} !== 5'b10100) begin
      n_err++;
      $display("FAIL flush_abort: got %b want 10100", {ex.O_busy, ex.O_alu_multicycle, ex.O_alu_ack, ex.O_in_ready, ex.O_out_valid});
    end
    step();
    n_cmp++;
    if ({ex.O_busy, ex.O_alu_ack, ex.O_out_valid, ex.O_timeout_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_idle: got %b want 0000", {ex.O_busy, ex.O_alu_ack, ex.O_out_valid, ex.O_timeout_err});
    end
  endtask

  task automatic test_timeout();
    ex.I_out_ready  = 1'b1;
    ex.I_in_valid   = 1'b1;
    ex.I_multicycle = 1'b1;
    step();
    ex.I_in_valid   = 1'b0;
    ex.I_multicycle = 1'b0;
    for (int i = 0; i < 80; i++) begin
      n_cmp++;
      if ({ex.O_alu_multicycle, ex.O_busy, ex.O_timeout_err} !== 3'b110) begin
        n_err++;
        $display("FAIL timeout_busy[%0d]: got %b want 110", i, {ex.O_alu_multicycle, ex.O_busy, ex.O_timeout_err});
      end
      step();
    end
    #1;
    n_cmp++;
    if ({ex.O_alu_multicycle, ex.O_alu_ack, ex.O_busy, ex.O_timeout_err, ex.O_in_ready} !== 5'b01110) begin
      n_err++;
      $display("FAIL timeout_abort: got %b want 01110", {ex.O_alu_multicycle, ex.O_alu_ack, ex.O_busy, ex.O_timeout_err, ex.O_in_ready});
    end
    step();
    ex.I_in_valid   = 1'b1;
    ex.I_alu_result = rnd64();
    step();
    ex.I_in_valid = 1'b0;
    n_cmp++;
    if ({ex.O_busy, ex.O_timeout_err, ex.O_out_valid} !== 3'b011) begin
      n_err++;
      $display("FAIL timeout_sticky: got %b want 011", {ex.O_busy, ex.O_timeout_err, ex.O_out_valid});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({ex.O_timeout_err, ex.O_out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL timeout_cleared: got %b want 00", {ex.O_timeout_err, ex.O_out_valid});
    end
  endtask

  // Randomized single-cycle traffic against an in-order result queue
  task automatic test_random();
    logic [63:0] q [$];
    logic        exp_ir;
    for (int c = 0; c < 400; c++) begin
      ex.I_in_valid   = 1'($urandom_range(0, 1));
      ex.I_multicycle = 1'b0;
      ex.I_flush      = ($urandom_range(0, 7) == 0);
      ex.I_out_ready  = 1'($urandom_range(0, 1));
      ex.I_alu_result = rnd64();
      #1;
      n_cmp++;
      if (ex.O_out_valid !== (q.size() != 0)) begin
        n_err++;
        $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, ex.O_out_valid, q.size() != 0);
      end else if (q.size() != 0 && ex.O_out_result !== q[0]) begin
        n_err++;
        $display("FAIL rnd_out_result[%0d]: got %h want %h", c, ex.O_out_result, q[0]);
      end
      exp_ir = ex.I_in_valid && !ex.I_flush && (q.size() == 0 || ex.I_out_ready);
      n_cmp++;
      if (ex.O_in_ready !== exp_ir) begin
        n_err++;
        $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, ex.O_in_ready, exp_ir);
      end
      if (q.size() != 0 && ex.I_out_ready) void'(q.pop_front());
      if (exp_ir) q.push_back(ex.I_alu_result);
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_busy();
    ex.I_out_ready  = 1'b0;
    ex.I_in_valid   = 1'b1;
    ex.I_multicycle = 1'b0;
    ex.I_alu_result = rnd64();
    step();
    ex.I_multicycle = 1'b1;
    step();
    step();
    step();
    n_cmp++;
    if ({ex.O_busy, ex.O_alu_multicycle, ex.O_out_valid} !== 3'b111) begin
      n_err++;
      $display("FAIL rstbusy_pre: got %b want 111", {ex.O_busy, ex.O_alu_multicycle, ex.O_out_valid});
    end
    rst = 1'b1;
    ex.I_in_valid   = 1'b0;
    ex.I_multicycle = 1'b0;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({ex.O_busy, ex.O_alu_multicycle, ex.O_out_valid, ex.O_timeout_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL rstbusy_post: got %b want 0000", {ex.O_busy, ex.O_alu_multicycle, ex.O_out_valid, ex.O_timeout_err});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_multicycle_done();
    test_flush_vs_valid();
    test_timeout();
    test_random();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
